// File: rtl/trace_dump.sv
// -----------------------------------------------------------------------------
// trace_dump
//   Streams a completed trace capture out of the trace RAM, one byte at a time,
//   oldest sample first. A dump starts at trace_end+1 (mod 512) and sends
//   NUM_SMPL bytes. The read address wraps at 9 bits.
//
//   Each byte passes through four states:
//     RD      - read strobe
//     LATCH   - RAM data registered into tx_data
//     SEND    - trmt pulse
//     WAIT_TX - wait for tx_done
//   This gives trmt 3 cycles after request acceptance or after the previous
//   tx_done.
//
// Handshake protocol: all control handshakes are single-cycle pulses. dump_req
//   is acted on only in IDLE. It is accepted when capture_done is high and
//   rejected with a one-cycle dump_err otherwise. trmt and tx_done form a
//   request/complete pair: one trmt is followed by exactly one tx_done.
//   dump_abort is a level and overrides everything, including a tx_done in the
//   same cycle.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   dump_req          pulse, start a dump
//   dump_abort        level, terminate an active dump
//   capture_done      trace RAM holds a completed capture
//   trace_end[8:0]    address of the newest captured sample
//   rdata[7:0]        RAM read data, valid the cycle after ren
//   tx_done           pulse, transmitter finished a byte
//   raddr[8:0], ren   RAM read address / read enable
//   tx_data[7:0]      byte to transmit
//   trmt              pulse, start transmission
//   clr_capture_done  pulse, release the capture unit at a normal finish
//   dump_busy         high in every state except IDLE
//   dump_done         pulse, dump completed normally
//   dump_err          pulse, request rejected (no capture available)
//   dbg_state[2:0]    current FSM state, for observation
// -----------------------------------------------------------------------------
module trace_dump #(
   parameter int NUM_SMPL = 512
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       dump_req,
   input  logic       dump_abort,
   input  logic       capture_done,
   input  logic [8:0] trace_end,
   input  logic [7:0] rdata,
   input  logic       tx_done,
   output logic [8:0] raddr,
   output logic       ren,
   output logic [7:0] tx_data,
   output logic       trmt,
   output logic       clr_capture_done,
   output logic       dump_busy,
   output logic       dump_done,
   output logic       dump_err,
   output logic [2:0] dbg_state
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD      = 3'd1,
      LATCH   = 3'd2,
      SEND    = 3'd3,
      WAIT_TX = 3'd4,
      FIN     = 3'd5
   } state_t;

   localparam logic [9:0] LAST_CNT = 10'(NUM_SMPL);

   state_t     state;
   state_t     state_nxt;
   logic [9:0] cnt;
   logic [9:0] cnt_inc;
   logic       accept;
   logic       byte_sent;

   assign cnt_inc   = cnt + 10'd1;
   assign accept    = (state == IDLE) && dump_req && capture_done;
   // An abort in the same cycle as tx_done cancels the byte bookkeeping too.
   assign byte_sent = (state == WAIT_TX) && tx_done && !dump_abort;
   assign dump_busy = (state != IDLE);
   assign dbg_state = state;

   always_comb begin
      state_nxt        = state;
      ren              = 1'b0;
      trmt             = 1'b0;
      clr_capture_done = 1'b0;
      dump_done        = 1'b0;
      case (state)
         IDLE:    if (accept) state_nxt = RD;
         RD: begin
            ren       = 1'b1;
            state_nxt = LATCH;
         end
         LATCH:   state_nxt = SEND;
         SEND: begin
            trmt      = 1'b1;
            state_nxt = WAIT_TX;
         end
         WAIT_TX: if (tx_done) state_nxt = (cnt_inc == LAST_CNT) ? FIN : RD;
         FIN: begin
            clr_capture_done = 1'b1;
            dump_done        = 1'b1;
            state_nxt        = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Abort wins in every active state; an aborted dump never releases
      // the capture unit.
      if ((state != IDLE) && dump_abort) begin
         state_nxt        = IDLE;
         clr_capture_done = 1'b0;
         dump_done        = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= IDLE;
         raddr    <= 9'd0;
         tx_data  <= 8'd0;
         cnt      <= 10'd0;
         dump_err <= 1'b0;
      end else begin
         state    <= state_nxt;
         dump_err <= (state == IDLE) && dump_req && !capture_done;
         // trace_end is sampled here only; later changes do not affect the dump.
         if (accept) begin
            raddr <= trace_end + 9'd1;
            cnt   <= 10'd0;
         end
         if (state == LATCH) tx_data <= rdata;
         if (byte_sent) begin
            cnt   <= cnt_inc;
            raddr <= raddr + 9'd1;
         end
      end
   end

endmodule

// File: tb/tb_trace_dump.sv
// -----------------------------------------------------------------------------
// tb_trace_dump
//   Bench for trace_dump. Everything runs in one process. The tick task steps
//   to the falling edge, models the trace RAM and the transmitter, and checks
//   outputs against scoreboard queues. The queues are filled when a dump
//   request is driven.
// -----------------------------------------------------------------------------
module tb_trace_dump;

   localparam int NUM_SMPL = 512;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       dump_req = 1'b0;
   logic       dump_abort = 1'b0;
   logic       capture_done = 1'b0;
   logic [8:0] trace_end = 9'd0;
   logic [7:0] rdata = 8'd0;
   logic       tx_done = 1'b0;
   logic [8:0] raddr;
   logic       ren;
   logic [7:0] tx_data;
   logic       trmt;
   logic       clr_capture_done;
   logic       dump_busy;
   logic       dump_done;
   logic       dump_err;
   logic [2:0] dbg_state;

   trace_dump #(.NUM_SMPL(NUM_SMPL)) dut (
      .clk(clk), .rst_n(rst_n), .dump_req(dump_req), .dump_abort(dump_abort),
      .capture_done(capture_done), .trace_end(trace_end), .rdata(rdata),
      .tx_done(tx_done), .raddr(raddr), .ren(ren), .tx_data(tx_data),
      .trmt(trmt), .clr_capture_done(clr_capture_done), .dump_busy(dump_busy),
      .dump_done(dump_done), .dump_err(dump_err), .dbg_state(dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int         checks = 0;
   int         failures = 0;
   logic [7:0] mem [512];
   logic [7:0] exp_q[$];
   logic [8:0] exp_addr_q[$];
   int         n_trmt, n_ren, n_clr, n_done, n_err, n_txdone, n_busy;
   bit         tx_pend = 1'b0;
   bit         rd_pend = 1'b0;
   int         tx_cnt = 0;
   int         tx_delay = -1;   // -1: random 0..3 per byte
   logic [8:0] rd_addr = 9'd0;
   logic [7:0] held = 8'd0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
      end
   endtask

   task automatic reset_counts();
      n_trmt = 0; n_ren = 0; n_clr = 0; n_done = 0;
      n_err = 0; n_txdone = 0; n_busy = 0;
   endtask

   task automatic flush();
      exp_q.delete();
      exp_addr_q.delete();
      tx_pend = 1'b0;
      rd_pend = 1'b0;
   endtask

   // One clock cycle: sample at the falling edge, run the RAM/transmitter
   // models, check strobes against the scoreboard.
   task automatic tick();
      @(negedge clk);
      tx_done = 1'b0;
      // RAM: data appears only for the cycle after ren, garbage otherwise.
      if (rd_pend) begin
         rdata   = mem[rd_addr];
         rd_pend = 1'b0;
      end else begin
         rdata = 8'($urandom);
      end
      if (ren) begin
         check("ren_expected", 32'(exp_addr_q.size() > 0), 32'd1);
         if (exp_addr_q.size() > 0) check("raddr", 32'(raddr), 32'(exp_addr_q.pop_front()));
         n_ren++;
         rd_pend = 1'b1;
         rd_addr = raddr;
      end
      // Transmitter: tx_done some cycles after trmt; tx_data must hold meanwhile.
      if (tx_pend) begin
         check("tx_hold", 32'(tx_data), 32'(held));
         if (tx_cnt == 0) begin
            tx_done = 1'b1;
            tx_pend = 1'b0;
            n_txdone++;
         end else begin
            tx_cnt--;
         end
      end
      if (trmt) begin
         check("trmt_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) check("tx_data", 32'(tx_data), 32'(exp_q.pop_front()));
         n_trmt++;
         tx_pend = 1'b1;
         tx_cnt  = (tx_delay < 0) ? int'($urandom_range(0, 3)) : tx_delay;
         held    = tx_data;
      end
      if (clr_capture_done) n_clr++;
      if (dump_done) n_done++;
      if (dump_err) n_err++;
      if (dump_busy) n_busy++;
   endtask

   // ---------------- driver tasks ----------------
   task automatic start_dump(input logic [8:0] te, input bit cd, input bit expect_accept);
      logic [8:0] a;
      trace_end    = te;
      capture_done = cd;
      dump_req     = 1'b1;
      if (expect_accept) begin
         for (int i = 0; i < NUM_SMPL; i++) begin
            a = te + 9'(1 + i);
            exp_addr_q.push_back(a);
            exp_q.push_back(mem[a]);
         end
      end
      tick();
      dump_req = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      int d0;
      d0 = n_done;
      for (int i = 0; i < budget && n_done == d0; i++) tick();
      check("dump_done_seen", 32'(n_done - d0), 32'd1);
   endtask

   task automatic check_reset_outputs(input string pfx);
      check({pfx, "_raddr"}, 32'(raddr), 32'd0);
      check({pfx, "_tx_data"}, 32'(tx_data), 32'd0);
      check({pfx, "_ren"}, 32'(ren), 32'd0);
      check({pfx, "_trmt"}, 32'(trmt), 32'd0);
      check({pfx, "_clr"}, 32'(clr_capture_done), 32'd0);
      check({pfx, "_busy"}, 32'(dump_busy), 32'd0);
      check({pfx, "_done"}, 32'(dump_done), 32'd0);
      check({pfx, "_err"}, 32'(dump_err), 32'd0);
   endtask

   task automatic full_dump(input logic [8:0] te, input bit disturb);
      reset_counts();
      tx_delay     = -1;
      capture_done = 1'b1;
      start_dump(te, 1'b1, 1'b1);
      check("busy_after_accept", 32'(dump_busy), 32'd1);
      if (disturb) begin
         // Changes to capture_done and trace_end mid-dump must be ignored.
         repeat (20) tick();
         capture_done = 1'b0;
         trace_end    = 9'h055;
      end
      wait_done(8000);
      tick();
      check("exp_q_empty", 32'(exp_q.size()), 32'd0);
      check("exp_addr_empty", 32'(exp_addr_q.size()), 32'd0);
      check("trmt_count", 32'(n_trmt), 32'(NUM_SMPL));
      check("ren_count", 32'(n_ren), 32'(NUM_SMPL));
      check("clr_count", 32'(n_clr), 32'd1);
      check("done_count", 32'(n_done), 32'd1);
      check("err_count", 32'(n_err), 32'd0);
      check("busy_end", 32'(dump_busy), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
      reset_counts();

      // Reset state
      rst_n = 1'b0;
      tick();
      tick();
      check_reset_outputs("rst");
      rst_n = 1'b1;
      tick();

      // Full dumps across the wrap points
      full_dump(9'h0FF, 1'b1);
      full_dump(9'h1FF, 1'b0);
      full_dump(9'h1FE, 1'b0);

      // Request without a capture is rejected
      reset_counts();
      start_dump(9'h0AA, 1'b0, 1'b0);
      check("err_pulse_now", 32'(dump_err), 32'd1);
      repeat (5) tick();
      check("err_count_nocap", 32'(n_err), 32'd1);
      check("ren_nocap", 32'(n_ren), 32'd0);
      check("busy_nocap", 32'(n_busy), 32'd0);

      // Abort together with the 10th tx_done
      reset_counts();
      tx_delay     = -1;
      capture_done = 1'b1;
      start_dump(9'h010, 1'b1, 1'b1);
      for (int i = 0; i < 600 && n_txdone < 10; i++) tick();
      check("txdone_10_reached", 32'(n_txdone), 32'd10);
      dump_abort = 1'b1;
      tick();
      check("abort_idle", 32'(dump_busy), 32'd0);
      dump_abort = 1'b0;
      tx_pend    = 1'b0;
      repeat (10) tick();
      check("abort_trmt_10_11", 32'(n_trmt >= 10 && n_trmt <= 11), 32'd1);
      check("abort_no_clr", 32'(n_clr), 32'd0);
      check("abort_no_done", 32'(n_done), 32'd0);
      check("abort_busy", 32'(dump_busy), 32'd0);
      flush();

      // Repeated requests while busy, slow transmitter
      reset_counts();
      tx_delay = 100;
      start_dump(9'h033, 1'b1, 1'b1);
      for (int i = 0; i < 350; i++) begin
         if (i % 37 == 5) begin
            dump_req  = 1'b1;
            trace_end = 9'($urandom);
         end
         tick();
         dump_req = 1'b0;
      end
      check("busy_no_err", 32'(n_err), 32'd0);
      check("busy_progress", 32'(n_trmt >= 3), 32'd1);
      check("busy_still", 32'(dump_busy), 32'd1);
      dump_abort = 1'b1;
      tick();
      dump_abort = 1'b0;
      flush();
      tick();
      check("busy_abort_idle", 32'(dump_busy), 32'd0);

      // Reset during WAIT_TX, then restart
      reset_counts();
      tx_delay = 20;
      start_dump(9'h0C0, 1'b1, 1'b1);
      for (int i = 0; i < 50 && n_trmt < 1; i++) tick();
      check("first_trmt_seen", 32'(n_trmt), 32'd1);
      repeat (5) tick();
      rst_n = 1'b0;
      flush();
      tick();
      check_reset_outputs("midrst");
      rst_n = 1'b1;
      repeat (3) tick();
      check("midrst_no_clr", 32'(n_clr), 32'd0);
      full_dump(9'h0C0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
